// File: rtl/clock_ctrl_pkg.sv
// Shared widths, default limits and mode encodings for the alarm clock controller.
package clock_ctrl_pkg;

  localparam int unsigned HR_W           = 5;
  localparam int unsigned MIN_W          = 6;
  localparam int unsigned RING_W         = 6;
  localparam int unsigned HR_MAX_DEF     = 23;
  localparam int unsigned MIN_MAX_DEF    = 59;
  localparam int unsigned RING_SECS_DEF  = 60;
  localparam int unsigned SNOOZE_MIN_DEF = 5;

  typedef enum logic [2:0] {
    MODE_RUN         = 3'd0,
    MODE_SET_HR      = 3'd1,
    MODE_SET_MIN     = 3'd2,
    MODE_SET_ALM_HR  = 3'd3,
    MODE_SET_ALM_MIN = 3'd4
  } mode_e;

  typedef struct packed {
    logic [HR_W-1:0]  hr;
    logic [MIN_W-1:0] mn;
  } hm_t;

endpackage

// File: rtl/mod_counter.sv
// Wrap-around counter 0..MAX with priority clear and a combinational carry-out.
module mod_counter #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned MAX   = 59
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o,
  output logic             carry_c
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             at_max;

  assign at_max  = (count_q == WIDTH'(MAX));
  assign carry_c = inc_i & at_max;
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = at_max ? '0 : count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/alarm_clock_ctrl.sv
// Mode FSM, timekeeping, alarm registers and ringing control for the clock datapath.
// Optional snooze support is built when SNOOZE_EN is defined.
module alarm_clock_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int unsigned HR_MAX     = HR_MAX_DEF,
  parameter int unsigned MIN_MAX    = MIN_MAX_DEF,
  parameter int unsigned RING_SECS  = RING_SECS_DEF,
  parameter int unsigned SNOOZE_MIN = SNOOZE_MIN_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             btn_mode,
  input  logic             btn_inc,
  input  logic             btn_off,
  output logic [HR_W-1:0]  hr,
  output logic [MIN_W-1:0] min,
  output logic [MIN_W-1:0] sec,
  output logic [HR_W-1:0]  alm_hr,
  output logic [MIN_W-1:0] alm_min,
  output logic [2:0]       mode,
  output logic             alarm_en,
  output logic             ringing
);

  mode_e mode_q;
  logic  in_run, in_set_hr, in_set_min, in_alm_hr, in_alm_min;
  logic  time_run, inc_ok;
  logic  sec_inc, sec_clr, sec_carry, min_inc, min_carry, hr_inc;
  logic  hr_carry_unused, alm_hr_carry_unused, alm_min_carry_unused;
  hm_t   new_hm, alm_hm;
  logic  alarm_hit, trigger, en_toggle;

  logic              alarm_en_q, alarm_en_d;
  logic              ringing_q, ringing_d;
  logic [RING_W-1:0] ring_cnt_q, ring_cnt_d, ring_cnt_inc;

  // Mode sequencing; illegal encodings fall back to RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_RUN;
    end else begin
      case (mode_q)
        MODE_RUN:         if (btn_mode) mode_q <= MODE_SET_HR;
        MODE_SET_HR:      if (btn_mode) mode_q <= MODE_SET_MIN;
        MODE_SET_MIN:     if (btn_mode) mode_q <= MODE_SET_ALM_HR;
        MODE_SET_ALM_HR:  if (btn_mode) mode_q <= MODE_SET_ALM_MIN;
        MODE_SET_ALM_MIN: if (btn_mode) mode_q <= MODE_RUN;
        default:          mode_q <= MODE_RUN;
      endcase
    end
  end

  assign in_run     = (mode_q == MODE_RUN);
  assign in_set_hr  = (mode_q == MODE_SET_HR);
  assign in_set_min = (mode_q == MODE_SET_MIN);
  assign in_alm_hr  = (mode_q == MODE_SET_ALM_HR);
  assign in_alm_min = (mode_q == MODE_SET_ALM_MIN);
  assign time_run   = in_run | in_alm_hr | in_alm_min;
  assign inc_ok     = btn_inc & ~btn_mode;

  // Setting-mode increments never carry into the next field
  assign sec_inc = tick & time_run;
  assign sec_clr = btn_mode & in_set_min;
  assign min_inc = sec_carry | (in_set_min & inc_ok);
  assign hr_inc  = (min_carry & time_run) | (in_set_hr & inc_ok);

  mod_counter #(.WIDTH(MIN_W), .MAX(MIN_MAX)) u_sec (
    .clk(clk), .rst_n(rst_n), .clr_i(sec_clr), .inc_i(sec_inc),
    .count_o(sec), .carry_c(sec_carry)
  );

  mod_counter #(.WIDTH(MIN_W), .MAX(MIN_MAX)) u_min (
    .clk(clk), .rst_n(rst_n), .clr_i(1'b0), .inc_i(min_inc),
    .count_o(min), .carry_c(min_carry)
  );

  mod_counter #(.WIDTH(HR_W), .MAX(HR_MAX)) u_hr (
    .clk(clk), .rst_n(rst_n), .clr_i(1'b0), .inc_i(hr_inc),
    .count_o(hr), .carry_c(hr_carry_unused)
  );

  mod_counter #(.WIDTH(HR_W), .MAX(HR_MAX)) u_alm_hr (
    .clk(clk), .rst_n(rst_n), .clr_i(1'b0), .inc_i(in_alm_hr & inc_ok),
    .count_o(alm_hr), .carry_c(alm_hr_carry_unused)
  );

  mod_counter #(.WIDTH(MIN_W), .MAX(MIN_MAX)) u_alm_min (
    .clk(clk), .rst_n(rst_n), .clr_i(1'b0), .inc_i(in_alm_min & inc_ok),
    .count_o(alm_min), .carry_c(alm_min_carry_unused)
  );

  // {hr,min} as it will be after a seconds rollover
  always_comb begin
    new_hm.hr = hr;
    new_hm.mn = min + MIN_W'(1);
    if (min == MIN_W'(MIN_MAX)) begin
      new_hm.mn = '0;
      new_hm.hr = (hr == HR_W'(HR_MAX)) ? '0 : hr + HR_W'(1);
    end
  end

  assign alm_hm.hr    = alm_hr;
  assign alm_hm.mn    = alm_min;
  assign alarm_hit    = sec_carry & alarm_en_q & (new_hm == alm_hm);
  assign ring_cnt_inc = ring_cnt_q + RING_W'(1);

`ifdef SNOOZE_EN
  localparam int unsigned SUM_W = MIN_W + 1;

  logic             snooze, snz_hit;
  logic             snz_valid_q, snz_valid_d;
  hm_t              snz_q, snz_d, snz_target;
  logic [SUM_W-1:0] snz_sum;

  assign snooze  = in_run & inc_ok & ringing_q;
  assign snz_hit = snz_valid_q & sec_carry & alarm_en_q & (new_hm == snz_q);
  assign trigger = alarm_hit | snz_hit;
  assign en_toggle = in_run & inc_ok & ~ringing_q;
  assign snz_sum = {1'b0, min} + SUM_W'(SNOOZE_MIN);

  always_comb begin
    snz_target.hr = hr;
    snz_target.mn = MIN_W'(snz_sum);
    if (snz_sum > SUM_W'(MIN_MAX)) begin
      snz_target.mn = MIN_W'(snz_sum - SUM_W'(MIN_MAX + 1));
      snz_target.hr = (hr == HR_W'(HR_MAX)) ? '0 : hr + HR_W'(1);
    end
  end

  always_comb begin
    snz_valid_d = snz_valid_q;
    snz_d       = snz_q;
    if (snz_hit) snz_valid_d = 1'b0;
    if (snooze) begin
      snz_valid_d = 1'b1;
      snz_d       = snz_target;
    end
    if (btn_off || !alarm_en_d) snz_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snz_valid_q <= 1'b0;
      snz_q       <= '0;
    end else begin
      snz_valid_q <= snz_valid_d;
      snz_q       <= snz_d;
    end
  end
`else
  assign trigger   = alarm_hit;
  assign en_toggle = in_run & inc_ok;
`endif

  // Ringing: set on a matching rollover, cleared by timeout, btn_off or disarm
  always_comb begin
    alarm_en_d = alarm_en_q ^ en_toggle;
    ringing_d  = ringing_q;
    ring_cnt_d = ring_cnt_q;
    if (ringing_q && tick) begin
      ring_cnt_d = ring_cnt_inc;
      if (ring_cnt_inc == RING_W'(RING_SECS)) ringing_d = 1'b0;
    end
    if (trigger) begin
      ringing_d  = 1'b1;
      ring_cnt_d = '0;
    end
`ifdef SNOOZE_EN
    if (snooze) ringing_d = 1'b0;
`endif
    if (btn_off || !alarm_en_d) ringing_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm_en_q <= 1'b0;
      ringing_q  <= 1'b0;
      ring_cnt_q <= '0;
    end else begin
      alarm_en_q <= alarm_en_d;
      ringing_q  <= ringing_d;
      ring_cnt_q <= ring_cnt_d;
    end
  end

  assign mode     = mode_q;
  assign alarm_en = alarm_en_q;
  assign ringing  = ringing_q;

endmodule
